// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered boot ROM between an instruction-fetch
// requester (m0) and a data-load requester (m1); one ROM transaction in flight at a time.
module rom_arbiter #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter int                ROM_DEPTH = 7,
  parameter int                ROM_LAT   = 1,
  parameter logic [DATA_W-1:0] ERR_DATA  = {DATA_W{1'b1}}
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              m0_stb_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_stb_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              rom_stb_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              busy_o
);

  localparam int                CNT_W   = $clog2(ROM_LAT + 1) + 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(ROM_DEPTH);
  localparam logic [CNT_W-1:0]  LAT_C   = CNT_W'(ROM_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              grant;       // 0 = m0, 1 = m1
  logic              last_grant;
  logic              req_any;
  logic              pick;
  logic              in_range;
  logic [ADDR_W-1:0] pick_addr;
  logic [CNT_W-1:0]  cnt;

  // On a tie the requester that was not served last wins.
  always_comb begin
    req_any   = m0_stb_i | m1_stb_i;
    pick      = (m0_stb_i & m1_stb_i) ? ~last_grant : m1_stb_i;
    pick_addr = pick ? m1_addr_i : m0_addr_i;
    in_range  = pick_addr < DEPTH_A;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  // NOTE: state_next is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_any) state_next = in_range ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt == '0) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rom_stb_o  <= 1'b0;
      rom_addr_o <= '0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_data_o  <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_data_o  <= '0;
    end else begin
      // Acks are registered on entry to RESP, so they last exactly that one cycle.
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            grant      <= pick;
            last_grant <= pick;
            if (in_range) begin
              rom_stb_o  <= 1'b1;
              rom_addr_o <= pick_addr;
              cnt        <= LAT_C;
            end else if (pick) begin
              m1_ack_o  <= 1'b1;
              m1_err_o  <= 1'b1;
              m1_data_o <= ERR_DATA;
            end else begin
              m0_ack_o  <= 1'b1;
              m0_err_o  <= 1'b1;
              m0_data_o <= ERR_DATA;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            rom_stb_o <= 1'b0;
            if (grant) begin
              m1_ack_o  <= 1'b1;
              m1_data_o <= rom_data_i;
            end else begin
              m0_ack_o  <= 1'b1;
              m0_data_o <= rom_data_i;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: transaction-level model checked every cycle on the ROM_LAT=1 build,
// plus directed literal checks on that build and on a ROM_LAT=3 build.
module tb_rom_arbiter;

  localparam int          ADDR_W = 16;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 7;
  localparam int          LAT    = 1;
  localparam logic [31:0] ERRW   = 32'hFFFF_FFFF;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic        m0_stb, m1_stb, m0_ack, m1_ack, m0_err, m1_err, rom_stb, busy;
  logic [15:0] m0_addr, m1_addr, rom_addr;
  logic [31:0] m0_data, m1_data, rom_data;

  logic        t3_stb, t3_ack, t3_err, rom_stb3, busy3;
  logic [15:0] t3_addr, rom_addr3;
  logic [31:0] t3_data, rom_data3;
  logic        d3_ack1, d3_err1;
  logic [31:0] d3_data1;

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_DEPTH(DEPTH), .ROM_LAT(LAT),
                .ERR_DATA(ERRW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_stb_i(m0_stb), .m0_addr_i(m0_addr), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_data_o(m0_data),
    .m1_stb_i(m1_stb), .m1_addr_i(m1_addr), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_data_o(m1_data),
    .rom_stb_o(rom_stb), .rom_addr_o(rom_addr), .rom_data_i(rom_data), .busy_o(busy)
  );

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_DEPTH(DEPTH), .ROM_LAT(3),
                .ERR_DATA(ERRW)) dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_stb_i(t3_stb), .m0_addr_i(t3_addr), .m0_ack_o(t3_ack), .m0_err_o(t3_err),
    .m0_data_o(t3_data),
    .m1_stb_i(1'b0), .m1_addr_i(16'h0000), .m1_ack_o(d3_ack1), .m1_err_o(d3_err1),
    .m1_data_o(d3_data1),
    .rom_stb_o(rom_stb3), .rom_addr_o(rom_addr3), .rom_data_i(rom_data3), .busy_o(busy3)
  );

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  // ROM models: junk whenever the address was not being strobed when it entered the pipe.
  always @(posedge sys_clk) rom_data <= rom_stb ? rom_word(rom_addr) : 32'hBAD1_0000;
  logic [31:0] pipe3 [3];
  always @(posedge sys_clk) begin
    pipe3[0] <= rom_stb3 ? rom_word(rom_addr3) : 32'hBAD3_0000;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rom_data3 = pipe3[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a request seen in an idle cycle T occupies T+1..ack; ack at
  // T+1 for an error, T+2+LAT otherwise; ROM strobed T+1..T+1+LAT.
  int          k      = 0;
  bit          tv     = 1'b0;
  int          t_start;
  int          t_ack  = -1;
  bit          t_grant, t_err;
  logic [15:0] t_addr;
  bit          last_g = 1'b1;
  logic        e_ack0, e_ack1, e_err0, e_err1, e_rom_stb, e_busy;
  logic [15:0] e_rom_addr;
  logic [31:0] e_data0, e_data1;

  always @(posedge sys_clk) begin
    k = k + 1;
    if (sys_rst) begin
      tv         = 1'b0;
      t_ack      = k - 1;
      last_g     = 1'b1;
      e_data0    = '0;
      e_data1    = '0;
      e_rom_addr = '0;
    end else if ((k - 1 > t_ack) && (m0_stb || m1_stb)) begin
      t_grant = (m0_stb && m1_stb) ? !last_g : m1_stb;
      last_g  = t_grant;
      t_addr  = t_grant ? m1_addr : m0_addr;
      t_err   = int'(t_addr) >= DEPTH;
      t_start = k - 1;
      t_ack   = t_err ? t_start + 1 : t_start + 2 + LAT;
      tv      = 1'b1;
      if (!t_err) e_rom_addr = t_addr;
    end
    e_busy    = tv && (k <= t_ack);
    e_rom_stb = tv && !t_err && (k >= t_start + 1) && (k <= t_start + 1 + LAT);
    e_ack0    = tv && (k == t_ack) && !t_grant;
    e_ack1    = tv && (k == t_ack) && t_grant;
    e_err0    = e_ack0 && t_err;
    e_err1    = e_ack1 && t_err;
    if (e_ack0) e_data0 = t_err ? ERRW : rom_word(t_addr);
    if (e_ack1) e_data1 = t_err ? ERRW : rom_word(t_addr);
  end

  always @(negedge sys_clk) begin
    if (k >= 1) begin
      check("cmp_ack0", 32'(m0_ack), 32'(e_ack0));
      check("cmp_ack1", 32'(m1_ack), 32'(e_ack1));
      check("cmp_err0", 32'(m0_err), 32'(e_err0));
      check("cmp_err1", 32'(m1_err), 32'(e_err1));
      check("cmp_data0", m0_data, e_data0);
      check("cmp_data1", m1_data, e_data1);
      check("cmp_rom_stb", 32'(rom_stb), 32'(e_rom_stb));
      check("cmp_rom_addr", 32'(rom_addr), 32'(e_rom_addr));
      check("cmp_busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  // Issue one request from an idle cycle and wait (bounded) for its ack.
  task automatic txn(input bit who, input logic [15:0] a, input int lat,
                     input logic [31:0] exp_data, input bit exp_err, input string name);
    bit done = 1'b0;
    next_cycle();
    if (who) begin m1_stb = 1'b1; m1_addr = a; end
    else     begin m0_stb = 1'b1; m0_addr = a; end
    for (int n = 1; n <= 10 && !done; n++) begin
      next_cycle();
      if (who ? m1_ack : m0_ack) begin
        done = 1'b1;
        check({name, "_lat"}, n, lat);
        check({name, "_data"}, who ? m1_data : m0_data, exp_data);
        check({name, "_err"}, 32'(who ? m1_err : m0_err), 32'(exp_err));
        m0_stb = 1'b0;
        m1_stb = 1'b0;
      end
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  int stamp [3];
  int n_ack;

  initial begin
    m0_stb = 0; m0_addr = 0; m1_stb = 0; m1_addr = 0; t3_stb = 0; t3_addr = 0;
    repeat (3) next_cycle();
    check("rst_ack0", 32'(m0_ack), 32'd0);
    check("rst_data0", m0_data, 32'd0);
    check("rst_rom_stb", 32'(rom_stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    sys_rst = 1'b0;
    next_cycle();

    // Single m0 read of address 2.
    m0_stb = 1'b1; m0_addr = 16'd2;
    next_cycle();
    check("t1_rom_stb_a", 32'(rom_stb), 32'd1);
    check("t1_rom_addr", 32'(rom_addr), 32'd2);
    next_cycle();
    check("t1_rom_stb_b", 32'(rom_stb), 32'd1);
    check("t1_ack_early", 32'(m0_ack), 32'd0);
    next_cycle();
    check("t1_ack", 32'(m0_ack), 32'd1);
    check("t1_data", m0_data, 32'hC0DE_0002);
    check("t1_rom_stb_off", 32'(rom_stb), 32'd0);
    m0_stb = 1'b0;
    next_cycle();
    check("t1_ack_pulse", 32'(m0_ack), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // Tie after reset: m0 first, m1 next, then the following tie goes to m0 again.
    sys_rst = 1'b1;
    next_cycle();
    sys_rst = 1'b0;
    m0_stb = 1'b1; m0_addr = 16'd1; m1_stb = 1'b1; m1_addr = 16'd3;
    repeat (3) next_cycle();
    check("t2_ack0", 32'(m0_ack), 32'd1);
    check("t2_ack1_quiet", 32'(m1_ack), 32'd0);
    check("t2_data0", m0_data, 32'hC0DE_0001);
    m0_stb = 1'b0;
    repeat (2) next_cycle();
    check("t2_rom_addr_m1", 32'(rom_addr), 32'd3);
    repeat (2) next_cycle();
    check("t2_ack1", 32'(m1_ack), 32'd1);
    check("t2_data1", m1_data, 32'hC0DE_0003);
    m1_stb = 1'b0;
    next_cycle();
    m0_stb = 1'b1; m0_addr = 16'd4; m1_stb = 1'b1; m1_addr = 16'd5;
    repeat (3) next_cycle();
    check("t2_tie2_ack0", 32'(m0_ack), 32'd1);
    check("t2_tie2_ack1", 32'(m1_ack), 32'd0);
    m0_stb = 1'b0;
    repeat (4) next_cycle();
    check("t2_tie2_m1", m1_data, 32'hC0DE_0005);
    m1_stb = 1'b0;

    // Out-of-range address on m1, then the boundaries on m0.
    next_cycle();
    m1_stb = 1'b1; m1_addr = 16'd7;
    next_cycle();
    check("t3_ack1", 32'(m1_ack), 32'd1);
    check("t3_err1", 32'(m1_err), 32'd1);
    check("t3_data1", m1_data, 32'hFFFF_FFFF);
    check("t3_rom_stb", 32'(rom_stb), 32'd0);
    m1_stb = 1'b0;
    next_cycle();
    check("t3_err_pulse", 32'(m1_err), 32'd0);
    check("t3_data_held", m1_data, 32'hFFFF_FFFF);
    txn(1'b0, 16'd6, 3, 32'hC0DE_0006, 1'b0, "t3_last_word");
    txn(1'b0, 16'hFFFF, 1, 32'hFFFF_FFFF, 1'b1, "t3_max_addr");
    txn(1'b1, 16'd0, 3, 32'hC0DE_0000, 1'b0, "t3_m1_zero");

    // m0 back-to-back with stb held and a fresh address on each ack.
    next_cycle();
    m0_stb = 1'b1; m0_addr = 16'd0; n_ack = 0;
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      if (m0_ack) begin
        if (n_ack < 3) stamp[n_ack] = k;
        check("t4_data", m0_data, rom_word(16'(n_ack)));
        n_ack++;
        if (n_ack == 3) m0_stb = 1'b0;
        else            m0_addr = 16'(n_ack);
      end
    end
    check("t4_ack_count", n_ack, 3);
    check("t4_gap1", stamp[1] - stamp[0], 4);
    check("t4_gap2", stamp[2] - stamp[1], 4);

    // Reset during WAIT aborts without ack; the next request is served normally.
    next_cycle();
    m0_stb = 1'b1; m0_addr = 16'd3;
    next_cycle();
    sys_rst = 1'b1; m0_stb = 1'b0;
    next_cycle();
    check("t5_rst_ack", 32'(m0_ack), 32'd0);
    check("t5_rst_rom_stb", 32'(rom_stb), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_data1", m1_data, 32'd0);
    sys_rst = 1'b0;
    next_cycle();
    check("t5_no_late_ack", 32'(m0_ack), 32'd0);
    txn(1'b1, 16'd5, 3, 32'hC0DE_0005, 1'b0, "t5_after_rst");

    // Requester drops stb mid-transaction: still acked.
    next_cycle();
    m0_stb = 1'b1; m0_addr = 16'd4;
    next_cycle();
    m0_stb = 1'b0;
    repeat (2) next_cycle();
    check("t5_drop_ack", 32'(m0_ack), 32'd1);
    check("t5_drop_data", m0_data, 32'hC0DE_0004);

    // ROM_LAT=3 build: ack at T+5, next held request acked 6 cycles later.
    next_cycle();
    t3_stb = 1'b1; t3_addr = 16'd2;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      check("t6_rom_stb", 32'(rom_stb3), 32'd1);
      check("t6_no_ack", 32'(t3_ack), 32'd0);
    end
    next_cycle();
    check("t6_ack", 32'(t3_ack), 32'd1);
    check("t6_data", t3_data, 32'hC0DE_0002);
    check("t6_rom_stb_off", 32'(rom_stb3), 32'd0);
    t3_addr = 16'd6;
    repeat (5) next_cycle();
    check("t6_ack2_early", 32'(t3_ack), 32'd0);
    next_cycle();
    check("t6_ack2", 32'(t3_ack), 32'd1);
    check("t6_data2", t3_data, 32'hC0DE_0006);
    t3_stb = 1'b0;
    next_cycle();
    t3_stb = 1'b1; t3_addr = 16'd7;
    next_cycle();
    check("t6_err_ack", 32'(t3_ack), 32'd1);
    check("t6_err", 32'(t3_err), 32'd1);
    check("t6_err_data", t3_data, 32'hFFFF_FFFF);
    t3_stb = 1'b0;

    repeat (3) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
